// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the conv layer scheduler.
package conv_sched_pkg;

  localparam int PIX_W    = 24;
  localparam int CH_W     = 4;
  localparam int OB_AW    = 12;
  localparam int NPIX_L0  = 182;
  localparam int NPIX_L1  = 132;
  localparam int OUT_W_L0 = 13;
  localparam int OUT_W_L1 = 11;
  localparam int PIX_CW   = 8;

  typedef enum logic [3:0] {
    IDLE, WLOAD, CLR, TRIG, WAITPX, WRITE, SAVE, NEXT, FIN
  } state_e;

  function automatic logic [PIX_CW-1:0] npix(input logic layer);
    return layer ? PIX_CW'(NPIX_L1) : PIX_CW'(NPIX_L0);
  endfunction

endpackage

// File: rtl/conv_sched_if.sv
// Control, weight-fetch, conv-engine and output-buffer signals of conv_sched.
interface conv_sched_if #(
  parameter int PIX_W = 24,
  parameter int CH_W  = 4,
  parameter int OB_AW = 12
);
  logic             start;
  logic             layer;
  logic [CH_W-1:0]  num_ch;
  logic             busy;
  logic             done;
  logic             wload_req;
  logic [CH_W-1:0]  wload_ch;
  logic             wload_ack;
  logic             conv_clear;
  logic             conv_trigger;
  logic             conv_layer;
  logic             conv_valid;
  logic [PIX_W-1:0] conv_pixel;
  logic             conv_save_done;
  logic             ob_we;
  logic [OB_AW-1:0] ob_addr;
  logic [PIX_W-1:0] ob_data;
  logic             ob_ack;

  modport master (
    input  start, layer, num_ch, wload_ack, conv_valid, conv_pixel, ob_ack,
    output busy, done, wload_req, wload_ch, conv_clear, conv_trigger,
           conv_layer, conv_save_done, ob_we, ob_addr, ob_data
  );

  modport slave (
    output start, layer, num_ch, wload_ack, conv_valid, conv_pixel, ob_ack,
    input  busy, done, wload_req, wload_ch, conv_clear, conv_trigger,
           conv_layer, conv_save_done, ob_we, ob_addr, ob_data
  );
endinterface

// File: rtl/conv_sched.sv
// Per-channel scheduler: fetch weights, run the conv engine, stream its pixels
// into the output buffer at ch*NPIX + pix.
module conv_sched #(
  parameter int PIX_W = conv_sched_pkg::PIX_W,
  parameter int CH_W  = conv_sched_pkg::CH_W,
  parameter int OB_AW = conv_sched_pkg::OB_AW
) (
  input logic          clk,
  input logic          rst,
  conv_sched_if.master bus
);
  import conv_sched_pkg::*;

  state_e              state_q, state_d;
  logic                layer_q, layer_d;
  logic [CH_W-1:0]     nch_q, nch_d, ch_q, ch_d;
  logic [PIX_CW-1:0]   pix_q, pix_d;
  logic [OB_AW-1:0]    base_q, base_d, addr_q, addr_d;
  logic [PIX_W-1:0]    data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      layer_q <= 1'b0;
      nch_q   <= '0;
      ch_q    <= '0;
      pix_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      nch_q   <= nch_d;
      ch_q    <= ch_d;
      pix_q   <= pix_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    nch_d   = nch_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    base_d  = base_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        layer_d = bus.layer;
        nch_d   = bus.num_ch;
        ch_d    = '0;
        pix_d   = '0;
        base_d  = '0;
        state_d = (bus.num_ch == '0) ? FIN : WLOAD;
      end
      WLOAD:  if (bus.wload_ack) state_d = CLR;
      CLR:    state_d = TRIG;
      TRIG:   state_d = WAITPX;
      WAITPX: if (bus.conv_valid) begin
        data_d  = bus.conv_pixel;
        addr_d  = base_q + OB_AW'(pix_q);
        state_d = WRITE;
      end
      WRITE: if (bus.ob_ack) begin
        if (pix_q == npix(layer_q) - PIX_CW'(1)) begin
          pix_d   = '0;
          state_d = NEXT;
        end else begin
          pix_d   = pix_q + PIX_CW'(1);
          state_d = SAVE;
        end
      end
      SAVE: state_d = WAITPX;
      // Channel base advances by NPIX each channel instead of multiplying.
      NEXT: if (ch_q == nch_q - CH_W'(1)) begin
        state_d = FIN;
      end else begin
        ch_d    = ch_q + CH_W'(1);
        base_d  = base_q + OB_AW'(npix(layer_q));
        state_d = WLOAD;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset gates every output low combinationally, except conv_clear which is forced high.
  always_comb begin
    bus.busy           = !rst && (state_q != IDLE);
    bus.done           = !rst && (state_q == FIN);
    bus.wload_req      = !rst && (state_q == WLOAD);
    bus.wload_ch       = bus.wload_req ? ch_q : '0;
    bus.conv_clear     = rst || (state_q == CLR) || (state_q == FIN);
    bus.conv_trigger   = !rst && (state_q == TRIG);
    bus.conv_layer     = bus.busy && layer_q;
    bus.conv_save_done = !rst && (state_q == SAVE);
    bus.ob_we          = !rst && (state_q == WRITE);
    bus.ob_addr        = rst ? '0 : addr_q;
    bus.ob_data        = rst ? '0 : data_q;
  end

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched with weight-loader, conv-engine and output-buffer responders.
module tb_conv_sched;

  logic clk;
  logic rst;

  conv_sched_if #(.PIX_W(24), .CH_W(4), .OB_AW(12)) bus ();

  conv_sched #(.PIX_W(24), .CH_W(4), .OB_AW(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [23:0] pixf(input int k);
    logic [23:0] m;
    m = 24'(k) * 24'h010307;
    return 24'hFFFF80 ^ m;
  endfunction

  // Run configuration, written only by the main process.
  int   epoch      = 0;
  int   cfg_wdly   = 1;
  int   cfg_odly   = 1;
  bit   cfg_inject = 1'b0;
  logic cfg_layer  = 1'b0;

  // Monitor results, written only by the monitor process.
  int wr_cnt, we_cyc, addr_err, data_err, stable_err, trig_cnt, save_cnt;
  int done_cnt, wl_cnt, wlch_err, clr_err, layer_err;
  logic [11:0] last_addr;
  logic [23:0] first_data;

  initial begin : wload_resp
    int wcnt;
    wcnt = 0;
    bus.wload_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.wload_req) begin
        wcnt++;
        bus.wload_ack = (wcnt == cfg_wdly);
      end else begin
        wcnt = 0;
        bus.wload_ack = 1'b0;
      end
    end
  end

  initial begin : ob_resp
    int ocnt;
    ocnt = 0;
    bus.ob_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ob_we) begin
        ocnt++;
        bus.ob_ack = (ocnt == cfg_odly);
      end else begin
        ocnt = 0;
        bus.ob_ack = 1'b0;
      end
    end
  end

  // Conv engine: one pixel per trigger/save_done, offered for a single cycle.
  initial begin : engine
    int ep, k;
    bit pending;
    ep = 0; k = 0; pending = 1'b0;
    bus.conv_valid = 1'b0;
    bus.conv_pixel = '0;
    forever begin
      @(negedge clk);
      if (ep != epoch) begin
        ep = epoch; k = 0; pending = 1'b0;
      end
      bus.conv_valid = 1'b0;
      if (pending) begin
        bus.conv_valid = 1'b1;
        bus.conv_pixel = pixf(k);
        k++;
        pending = 1'b0;
      end else if (cfg_inject && bus.wload_req) begin
        bus.conv_valid = 1'b1;
        bus.conv_pixel = 24'hDEAD00;
      end
      if (bus.conv_trigger || bus.conv_save_done) pending = 1'b1;
    end
  end

  initial begin : monitor
    int ep;
    logic pwe, pwl, clr_flag;
    logic [11:0] paddr;
    logic [23:0] pdata;
    ep = -1; pwe = 1'b0; pwl = 1'b0; clr_flag = 1'b0; paddr = '0; pdata = '0;
    forever begin
      @(negedge clk);
      if (ep != epoch) begin
        ep = epoch;
        wr_cnt = 0; we_cyc = 0; addr_err = 0; data_err = 0; stable_err = 0;
        trig_cnt = 0; save_cnt = 0; done_cnt = 0; wl_cnt = 0; wlch_err = 0;
        clr_err = 0; layer_err = 0; last_addr = '0; first_data = '0;
        pwe = 1'b0; pwl = 1'b0; clr_flag = 1'b0;
      end
      if (bus.ob_we) begin
        we_cyc++;
        if (!pwe) begin
          if (bus.ob_addr !== 12'(wr_cnt)) addr_err++;
          if (bus.ob_data !== pixf(wr_cnt)) data_err++;
          if (wr_cnt == 0) first_data = bus.ob_data;
          last_addr = bus.ob_addr;
          wr_cnt++;
        end else if (bus.ob_addr !== paddr || bus.ob_data !== pdata) begin
          stable_err++;
        end
        paddr = bus.ob_addr;
        pdata = bus.ob_data;
      end
      pwe = bus.ob_we;
      if (bus.wload_req && !pwl) begin
        if (bus.wload_ch !== 4'(wl_cnt)) wlch_err++;
        wl_cnt++;
      end
      pwl = bus.wload_req;
      if (bus.conv_clear) clr_flag = 1'b1;
      if (bus.conv_trigger) begin
        trig_cnt++;
        if (!clr_flag) clr_err++;
        clr_flag = 1'b0;
      end
      if (bus.conv_save_done) save_cnt++;
      if (bus.done) done_cnt++;
      if (bus.busy && bus.conv_layer !== cfg_layer) layer_err++;
      if (!bus.busy && bus.conv_layer !== 1'b0) layer_err++;
    end
  end

  task automatic launch(input logic lay, input logic [3:0] nch, input int wd, input int od,
                        input bit inj);
    epoch++;
    cfg_layer  = lay;
    cfg_wdly   = wd;
    cfg_odly   = od;
    cfg_inject = inj;
    repeat (2) @(negedge clk);
    bus.layer  = lay;
    bus.num_ch = nch;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit restart);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40000 && !seen; i++) begin
      @(negedge clk);
      if (restart && i == 20) begin
        bus.start  = 1'b1;
        bus.layer  = ~cfg_layer;
        bus.num_ch = 4'd5;
      end
      if (restart && i == 23) bus.start = 1'b0;
      seen = bus.done;
    end
    check_eq(tag, 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    int we_snap, wr_snap;
    bit hit;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.layer = 1'b0;
    bus.num_ch = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_busy",      32'(bus.busy),       32'd0);
    check_eq("rst_ob_we",     32'(bus.ob_we),      32'd0);
    check_eq("rst_clear",     32'(bus.conv_clear), 32'd1);
    check_eq("rst_done",      32'(bus.done),       32'd0);
    check_eq("rst_wload_req", 32'(bus.wload_req),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_busy",  32'(bus.busy),       32'd0);
    check_eq("idle_clear", 32'(bus.conv_clear), 32'd0);

    // Reset held for three cycles while a write is outstanding.
    launch(1'b0, 4'd1, 1, 6, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = bus.ob_we;
    end
    check_eq("mid_reach_write", 32'(hit), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mid_rst_busy",  32'(bus.busy),       32'd0);
      check_eq("mid_rst_ob_we", 32'(bus.ob_we),      32'd0);
      check_eq("mid_rst_clear", 32'(bus.conv_clear), 32'd1);
    end
    rst = 1'b0;
    we_snap = we_cyc;
    wr_snap = wr_cnt;
    @(negedge clk);
    check_eq("mid_rel_idle", 32'(bus.busy), 32'd0);
    repeat (20) @(negedge clk);
    check_eq("mid_no_done",   32'(done_cnt), 32'd0);
    check_eq("mid_no_we",     32'(we_cyc),   32'(we_snap));
    check_eq("mid_no_writes", 32'(wr_cnt),   32'(wr_snap));

    // conv1, two channels, weights after 2 cycles, immediate buffer ack.
    launch(1'b0, 4'd2, 2, 1, 1'b0);
    wait_done("l0c2_done_seen", 1'b0);
    check_eq("l0c2_writes",    32'(wr_cnt),    32'd364);
    check_eq("l0c2_we_cycles", 32'(we_cyc),    32'd364);
    check_eq("l0c2_addr_seq",  32'(addr_err),  32'd0);
    check_eq("l0c2_last_addr", 32'(last_addr), 32'd363);
    check_eq("l0c2_data",      32'(data_err),  32'd0);
    check_eq("l0c2_triggers",  32'(trig_cnt),  32'd2);
    check_eq("l0c2_saves",     32'(save_cnt),  32'd362);
    check_eq("l0c2_dones",     32'(done_cnt),  32'd1);
    check_eq("l0c2_wload_ch",  32'(wlch_err),  32'd0);
    check_eq("l0c2_clr_trig",  32'(clr_err),   32'd0);
    check_eq("l0c2_layer",     32'(layer_err), 32'd0);

    // conv2, one channel, buffer ack after 5 cycles.
    launch(1'b1, 4'd1, 1, 5, 1'b0);
    wait_done("l1c1_done_seen", 1'b0);
    check_eq("l1c1_writes",     32'(wr_cnt),     32'd132);
    check_eq("l1c1_we_cycles",  32'(we_cyc),     32'd660);
    check_eq("l1c1_stable",     32'(stable_err), 32'd0);
    check_eq("l1c1_last_addr",  32'(last_addr),  32'd131);
    check_eq("l1c1_first_data", 32'(first_data), 32'h00FFFF80);
    check_eq("l1c1_data",       32'(data_err),   32'd0);
    check_eq("l1c1_saves",      32'(save_cnt),   32'd131);
    check_eq("l1c1_layer",      32'(layer_err),  32'd0);

    // Zero channels: straight to FIN.
    launch(1'b0, 4'd0, 1, 1, 1'b0);
    check_eq("zero_done_pulse", 32'(bus.done), 32'd1);
    check_eq("zero_busy",       32'(bus.busy), 32'd1);
    @(negedge clk);
    check_eq("zero_done_once",  32'(bus.done), 32'd0);
    check_eq("zero_idle",       32'(bus.busy), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("zero_wload",   32'(wl_cnt),   32'd0);
    check_eq("zero_trigger", 32'(trig_cnt), 32'd0);
    check_eq("zero_writes",  32'(we_cyc),   32'd0);
    check_eq("zero_dones",   32'(done_cnt), 32'd1);

    // Re-start while busy and spurious conv_valid during WLOAD.
    launch(1'b0, 4'd1, 3, 2, 1'b1);
    wait_done("ign_done_seen", 1'b1);
    check_eq("ign_writes",   32'(wr_cnt),    32'd182);
    check_eq("ign_data",     32'(data_err),  32'd0);
    check_eq("ign_addr_seq", 32'(addr_err),  32'd0);
    check_eq("ign_dones",    32'(done_cnt),  32'd1);
    check_eq("ign_triggers", 32'(trig_cnt),  32'd1);
    check_eq("ign_layer",    32'(layer_err), 32'd0);

    // Full conv1 run over 15 channels.
    launch(1'b0, 4'd15, 1, 1, 1'b0);
    wait_done("full_done_seen", 1'b0);
    check_eq("full_writes",    32'(wr_cnt),    32'd2730);
    check_eq("full_last_addr", 32'(last_addr), 32'd2729);
    check_eq("full_addr_seq",  32'(addr_err),  32'd0);
    check_eq("full_wload_n",   32'(wl_cnt),    32'd15);
    check_eq("full_wload_ch",  32'(wlch_err),  32'd0);
    check_eq("full_triggers",  32'(trig_cnt),  32'd15);
    check_eq("full_clr_trig",  32'(clr_err),   32'd0);
    check_eq("full_dones",     32'(done_cnt),  32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
